mem_master: RTL and testbench

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master.sv | 160 ++++++++++++++++
 tb/tb_mem_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// mem_master: burst command front end for a single-port word memory.
// Accepts one write or read burst at a time. Memory strobes (r_w, addr, wdata)
// are registered. Read data is captured RD_LAT cycles after the address issues
// and held for the downstream ready/valid handshake.
module mem_master #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1    // legal range 1..4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [ADDR_W-1:0] cmd_len_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              rd_ready_i,
    output logic              r_w_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_HOLD,
        S_DONE
    } state_e;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] beats_left_q, beats_left_d;
    logic [2:0]        lat_q, lat_d;
    logic              r_w_q, r_w_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            lat_q        <= '0;
            r_w_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            lat_q        <= lat_d;
            r_w_q        <= r_w_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Next-state and datapath update; r_w defaults low so it only pulses per accepted beat.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        lat_d        = lat_q;
        r_w_d        = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    cur_addr_d   = cmd_addr_i;
                    beats_left_d = cmd_len_i;
                    if (cmd_wr_i) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_WR: begin
                if (wr_valid_i) begin
                    r_w_d      = 1'b1;
                    addr_d     = cur_addr_q;
                    wdata_d    = wr_data_i;
                    cur_addr_d = cur_addr_q + 1'b1;
                    if (beats_left_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        beats_left_d = beats_left_q - 1'b1;
                    end
                end
            end
            S_RD_ISSUE: begin
                addr_d  = cur_addr_q;
                lat_d   = LAT_LOAD;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_q <= 3'd1) begin
                    lat_d      = '0;
                    rd_data_d  = rdata_i;
                    rd_valid_d = 1'b1;
                    state_d    = S_RD_HOLD;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_RD_HOLD: begin
                if (rd_ready_i) begin
                    rd_valid_d = 1'b0;
                    cur_addr_d = cur_addr_q + 1'b1;
                    if (beats_left_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        beats_left_d = beats_left_q - 1'b1;
                        state_d      = S_RD_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign wr_ready_o  = (state_q == S_WR);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign r_w_o       = r_w_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a 16x8 memory model (combinational read,
// write on rising edge while r_w is high, matching RD_LAT = 1).
module tb_mem_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_wr = 1'b0;
    logic [3:0] cmd_addr = '0;
    logic [3:0] cmd_len = '0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_ready = 1'b0;
    logic [7:0] rdata;
    logic       cmd_ready_o, wr_ready_o, rd_valid_o, r_w_o, busy_o, done_o;
    logic [7:0] rd_data_o, wdata_o;
    logic [3:0] addr_o;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] mem [16] = '{default: 8'h00};
    logic [3:0] wlog_a[$];
    logic [7:0] wlog_d[$];
    int         done_cnt = 0;

    logic [7:0] wq[$];
    logic [7:0] rd_got[$];
    bit         rd_timeout;
    bit         rdy_seen;
    int         hold_ok;

    mem_master #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready),
        .r_w_o(r_w_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Memory model
    always @(posedge clk) if (r_w_o === 1'b1) mem[addr_o] <= wdata_o;
    assign rdata = mem[addr_o];

    // Log every write strobe and done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (r_w_o === 1'b1) begin
            wlog_a.push_back(addr_o);
            wlog_d.push_back(wdata_o);
        end
        if (done_o === 1'b1) done_cnt++;
    end

    task automatic issue_cmd(input logic wr, input logic [3:0] a, input logic [3:0] len);
        cmd_wr = wr; cmd_addr = a; cmd_len = len; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_write(input logic [3:0] a, input logic [3:0] len, input int gap_at);
        issue_cmd(1'b1, a, len);
        for (int i = 0; i < int'(wq.size()); i++) begin
            if (i == gap_at) begin
                wr_valid = 1'b0; wr_data = 8'hEE;
                @(posedge clk); #1;
            end
            wr_valid = 1'b1; wr_data = wq[i];
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_read(input logic [3:0] a, input logic [3:0] len, input int hold, input bit poke);
        int waited;
        logic [7:0] first;
        rd_got.delete(); rd_timeout = 1'b0; hold_ok = 0; rdy_seen = 1'b0;
        rd_ready = (hold == 0);
        issue_cmd(1'b0, a, len);
        for (int b = 0; b <= int'(len); b++) begin
            waited = 0;
            @(negedge clk);
            if (cmd_ready_o) rdy_seen = 1'b1;
            while (!rd_valid_o && waited < 20) begin
                @(negedge clk);
                waited++;
                if (cmd_ready_o) rdy_seen = 1'b1;
            end
            if (!rd_valid_o) begin
                rd_timeout = 1'b1;
                break;
            end
            rd_got.push_back(rd_data_o);
            if (b == 0 && hold > 0) begin
                first = rd_data_o;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    if (rd_valid_o === 1'b1 && rd_data_o === first) hold_ok++;
                end
                rd_ready = 1'b1;
            end
            if (poke && b == 1) begin
                cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd9; cmd_len = 4'd0;
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rd_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (r_w_o !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b want 0", r_w_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_o); end
        n_checks++; if (addr_o !== 4'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr_o); end
        n_checks++; if (wdata_o !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", wdata_o); end
        n_checks++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid_o); end
        n_checks++; if (rd_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data_o); end
        n_checks++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    endtask

    task automatic test_write_burst;
        logic [3:0] ea [4] = '{4'd2, 4'd3, 4'd4, 4'd5};
        logic [7:0] ed [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        int d0;
        wlog_a.delete(); wlog_d.delete(); d0 = done_cnt;
        wq = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
        run_write(4'd2, 4'd3, -1);
        n_checks++; if (wlog_a.size() != 4) begin n_fail++; $display("FAIL wr_count: got %0d want 4", wlog_a.size()); end
        if (wlog_a.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (wlog_a[i] !== ea[i] || wlog_d[i] !== ed[i]) begin n_fail++;
                    $display("FAIL wr_beat%0d: got %h@%h want %h@%h", i, wlog_d[i], wlog_a[i], ed[i], ea[i]); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem[ea[i]] !== ed[i]) begin n_fail++; $display("FAIL wr_mem%0d: got %h want %h", i, mem[ea[i]], ed[i]); end
        end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL wr_done: got %0d pulses want 1", done_cnt - d0); end
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL wr_idle_ready: got %b want 1", cmd_ready_o); end
    endtask

    task automatic test_read_burst;
        logic [7:0] ed [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        int w0;
        w0 = wlog_a.size();
        run_read(4'd2, 4'd3, 0, 1'b0);
        n_checks++; if (rd_timeout) begin n_fail++; $display("FAIL rd_timeout: got %0d beats want 4", rd_got.size()); end
        n_checks++; if (rd_got.size() != 4) begin n_fail++; $display("FAIL rd_count: got %0d want 4", rd_got.size()); end
        if (rd_got.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (rd_got[i] !== ed[i]) begin n_fail++; $display("FAIL rd_beat%0d: got %h want %h", i, rd_got[i], ed[i]); end
            end
        end
        n_checks++; if (wlog_a.size() != w0) begin n_fail++; $display("FAIL rd_no_write: got %0d strobes want 0", wlog_a.size() - w0); end
    endtask

    task automatic test_wrap;
        logic [3:0] ea [3] = '{4'd14, 4'd15, 4'd0};
        logic [7:0] ed [3] = '{8'h11, 8'h22, 8'h33};
        wlog_a.delete(); wlog_d.delete();
        wq = {8'h11, 8'h22, 8'h33};
        run_write(4'd14, 4'd2, -1);
        n_checks++; if (wlog_a.size() != 3) begin n_fail++; $display("FAIL wrap_wr_count: got %0d want 3", wlog_a.size()); end
        if (wlog_a.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (wlog_a[i] !== ea[i] || wlog_d[i] !== ed[i]) begin n_fail++;
                    $display("FAIL wrap_wr%0d: got %h@%h want %h@%h", i, wlog_d[i], wlog_a[i], ed[i], ea[i]); end
            end
        end
        run_read(4'd14, 4'd2, 0, 1'b0);
        n_checks++; if (rd_got.size() != 3) begin n_fail++; $display("FAIL wrap_rd_count: got %0d want 3", rd_got.size()); end
        if (rd_got.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (rd_got[i] !== ed[i]) begin n_fail++; $display("FAIL wrap_rd%0d: got %h want %h", i, rd_got[i], ed[i]); end
            end
        end
    endtask

    task automatic test_back_pressure;
        wlog_a.delete(); wlog_d.delete();
        wq = {8'h55, 8'h66};
        run_write(4'd6, 4'd1, 1);
        n_checks++; if (wlog_a.size() != 2) begin n_fail++; $display("FAIL gap_wr_count: got %0d want 2", wlog_a.size()); end
        if (wlog_a.size() == 2) begin
            n_checks++; if (wlog_a[0] !== 4'd6 || wlog_d[0] !== 8'h55) begin n_fail++; $display("FAIL gap_wr0: got %h@%h want 55@6", wlog_d[0], wlog_a[0]); end
            n_checks++; if (wlog_a[1] !== 4'd7 || wlog_d[1] !== 8'h66) begin n_fail++; $display("FAIL gap_wr1: got %h@%h want 66@7", wlog_d[1], wlog_a[1]); end
        end
        n_checks++; if (mem[7] !== 8'h66) begin n_fail++; $display("FAIL gap_mem7: got %h want 66", mem[7]); end
        run_read(4'd6, 4'd1, 5, 1'b0);
        n_checks++; if (hold_ok != 5) begin n_fail++; $display("FAIL hold_stable: got %0d stable cycles want 5", hold_ok); end
        n_checks++; if (rd_got.size() != 2) begin n_fail++; $display("FAIL hold_rd_count: got %0d want 2", rd_got.size()); end
        if (rd_got.size() == 2) begin
            n_checks++; if (rd_got[0] !== 8'h55 || rd_got[1] !== 8'h66) begin n_fail++; $display("FAIL hold_rd_data: got %h,%h want 55,66", rd_got[0], rd_got[1]); end
        end
    endtask

    task automatic test_reset_mid_burst;
        wlog_a.delete(); wlog_d.delete();
        issue_cmd(1'b1, 4'd8, 4'd3);
        wr_valid = 1'b1; wr_data = 8'hC0; @(posedge clk); #1;
        wr_data = 8'hC1; @(posedge clk); #1;
        wr_data = 8'hC2; @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (r_w_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rw: got %b want 0", r_w_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
        n_checks++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wr_ready: got %b want 0", wr_ready_o); end
        wr_data = 8'hC3;
        repeat (2) @(posedge clk);
        #1;
        wr_valid = 1'b0; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", cmd_ready_o); end
        n_checks++; if (wlog_a.size() != 2) begin n_fail++; $display("FAIL rst_mid_strobes: got %0d want 2", wlog_a.size()); end
        n_checks++; if (mem[8] !== 8'hC0 || mem[9] !== 8'hC1) begin n_fail++; $display("FAIL rst_mid_kept: got %h,%h want C0,C1", mem[8], mem[9]); end
        n_checks++; if (mem[10] !== 8'h00 || mem[11] !== 8'h00) begin n_fail++; $display("FAIL rst_mid_untouched: got %h,%h want 00,00", mem[10], mem[11]); end
        wlog_a.delete(); wlog_d.delete();
        wq = {8'h5A};
        run_write(4'd12, 4'd0, -1);
        n_checks++; if (wlog_a.size() != 1 || mem[12] !== 8'h5A) begin n_fail++; $display("FAIL rst_after_write: got %0d strobes mem=%h want 1 strobe mem=5A", wlog_a.size(), mem[12]); end
    endtask

    task automatic test_cmd_while_busy;
        logic [7:0] ed [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        int w0, d0;
        w0 = wlog_a.size(); d0 = done_cnt;
        run_read(4'd2, 4'd3, 0, 1'b1);
        n_checks++; if (rd_got.size() != 4) begin n_fail++; $display("FAIL busy_rd_count: got %0d want 4", rd_got.size()); end
        if (rd_got.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (rd_got[i] !== ed[i]) begin n_fail++; $display("FAIL busy_rd%0d: got %h want %h", i, rd_got[i], ed[i]); end
            end
        end
        n_checks++; if (rdy_seen) begin n_fail++; $display("FAIL busy_cmd_ready: got 1 during burst want 0"); end
        n_checks++; if (wlog_a.size() != w0) begin n_fail++; $display("FAIL busy_stray_write: got %0d strobes want 0", wlog_a.size() - w0); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL busy_done: got %0d pulses want 1", done_cnt - d0); end
        n_checks++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_end_idle: got ready=%b busy=%b want 1,0", cmd_ready_o, busy_o); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_back_pressure();
        test_reset_mid_burst();
        test_cmd_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
